mips_mc_control: RTL
====================

MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 Parameter SHALL be TRAP_ILLEGAL, default 1; 1 = unknown opcode/funct enters HALT, 0 = treated as NOP, back to FETCH.
REQ-002 Port SHALL be clk  input  1  single clock, rising-edge active.
REQ-003 Port SHALL be rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port SHALL be opcode  input  6  instruction[31:26], valid from DECODE onward.
REQ-005 Port SHALL be funct  input  6  instruction[5:0], valid from DECODE onward.
REQ-006 Port SHALL be zero  input  1  ALU Z flag, sampled in BRANCH.
REQ-007 Ports SHALL be ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, alu_src_a  output  1 each  datapath strobes/selects.
REQ-008 Ports SHALL be alu_src_b  output  2  (0 reg B, 1 const 4, 2 sign-ext imm, 3 sign-ext imm<<2) and pc_src  output  2  (0 ALU result, 1 ALU-out register, 2 jump target).
REQ-009 Port SHALL be alu_op  output  4  ALU operation code.
REQ-010 Port SHALL be pc_en  output  1  PC load enable.
REQ-011 Ports SHALL be halted  output  1  and state  output  4  (debug).

Function
REQ-012 Block SHALL be a Moore FSM; all outputs except pc_en are decoded from registered state plus registered opcode/funct captured in DECODE.
REQ-013 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, HALT.
REQ-014 FETCH: mem_read=1, iord=0, ir_write=1, alu_src_a=0, alu_src_b=1, alu_op=0010, pc_src=0, pc_write=1; next DECODE.
REQ-015 DECODE: alu_src_a=0, alu_src_b=3, alu_op=0010 (branch target precompute), latch opcode/funct; next by opcode: 100011/101011 MEMADR, 000000 or immediate-ALU class EXEC, 000100/000101 BRANCH, 000010 JUMP, else HALT or FETCH per TRAP_ILLEGAL.
REQ-016 MEMADR: alu_src_a=1, alu_src_b=2, alu_op=0010; next MEMRD (lw) or MEMWR (sw).
REQ-017 MEMRD: mem_read=1, iord=1 -> MEMWB; MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH; MEMWR: mem_write=1, iord=1 -> FETCH.
REQ-018 EXEC: alu_src_a=1; R-type alu_src_b=0 with funct map 100000/100001 0010, 100010/100011 0110, 100100 0000, 100101 0001, 100110 0011, 100111 1100, 101010 0111; immediates alu_src_b=2 with 001000 0010, 001100 0000, 001101 0001, 001110 0011, 001010 0111; unmapped funct handled per REQ-001; next ALUWB.
REQ-019 ALUWB: reg_write=1, mem_to_reg=0, reg_dst=1 for R-type else 0; next FETCH.
REQ-020 BRANCH: alu_src_a=1, alu_src_b=0, alu_op=0110, pc_src=1; pc_en=zero for beq, ~zero for bne; next FETCH.
REQ-021 JUMP: pc_src=2, pc_write=1; next FETCH.
REQ-022 pc_en SHALL equal pc_write OR (BRANCH taken), combinational from state, latched opcode and zero.
REQ-023 Strobes not listed for a state SHALL be 0; selects not listed SHALL be 0; alu_op default 0010.
REQ-024 HALT SHALL be absorbing (all strobes 0, halted=1) until reset.
REQ-025 Instruction latencies SHALL be: lw 5, sw 4, R/imm 4, beq/bne 3, j 3 cycles.

Reset
REQ-026 rst_n low SHALL force state=FETCH, latched opcode/funct=0, halted=0 immediately, regardless of clk.
REQ-027 Reset asserted mid-instruction SHALL abort it; no write strobe asserted after rst_n falls.
REQ-028 First rising edge after rst_n rises SHALL execute FETCH outputs (already presented during reset).

Structure
REQ-029 Shared package SHALL hold state encoding, opcode/funct constants and ALU op codes (0000,0001,0010,0011,0110,0111,1100) used by ALU and this block.
REQ-030 One sub-module mips_alu_dec (combinational opcode/funct -> alu_op, is_legal) SHALL be instantiated.

Verification
REQ-031 Reset release, opcode 100011 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; reg_write=1, mem_to_reg=1 only in MEMWB.
REQ-032 opcode 000000 funct 100111 -> EXEC alu_op=1100, ALUWB reg_dst=1; funct 101010 -> alu_op=0111.
REQ-033 opcode 000100, zero=1 -> pc_en=1 in BRANCH; zero=0 -> pc_en=0; opcode 000101 inverted.
REQ-034 opcode 111111, TRAP_ILLEGAL=1 -> HALT, halted=1, held 10 cycles; TRAP_ILLEGAL=0 -> FETCH after DECODE.
REQ-035 rst_n low during MEMWR -> mem_write drops without clk edge, state=FETCH.
REQ-036 opcode 001101 -> EXEC alu_src_b=2, alu_op=0001; ALUWB reg_dst=0.

Source files
------------

// File: rtl/mips_mc_control_pkg.sv
// Shared encodings for the multicycle MIPS controller and ALU: states, opcodes, functs, ALU ops,
// plus the per-state control decode used to build the registered control word.
package mips_mc_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_HALT   = 4'd10
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef struct packed {
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
    logic       pc_write;
    logic       halted;
  } ctrl_t;

  // Control word presented while in state s; rtype/exec_op describe the latched instruction.
  function automatic ctrl_t ctrl_outs(state_e s, logic rtype, logic [3:0] exec_op);
    ctrl_t c;
    c        = '0;
    c.alu_op = ALU_ADD;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = 2'd1;
        c.pc_write  = 1'b1;
      end
      S_DECODE: c.alu_src_b = 2'd3;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = rtype ? 2'd0 : 2'd2;
        c.alu_op    = exec_op;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = rtype;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_SUB;
        c.pc_src    = 2'd1;
      end
      S_JUMP: begin
        c.pc_src   = 2'd2;
        c.pc_write = 1'b1;
      end
      S_HALT:  c.halted = 1'b1;
      default: c.halted = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_mc_control_alu_dec.sv
// Combinational opcode/funct decode: ALU operation for the EXEC step and instruction legality.
module mips_alu_dec
  import mips_mc_control_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_op_o,
  output logic       is_legal_o
);

  always_comb begin
    alu_op_o   = ALU_ADD;
    is_legal_o = 1'b1;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD, FN_ADDU: alu_op_o = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op_o = ALU_SUB;
          FN_AND:          alu_op_o = ALU_AND;
          FN_OR:           alu_op_o = ALU_OR;
          FN_XOR:          alu_op_o = ALU_XOR;
          FN_NOR:          alu_op_o = ALU_NOR;
          FN_SLT:          alu_op_o = ALU_SLT;
          default:         is_legal_o = 1'b0;
        endcase
      end
      OP_ADDI: alu_op_o = ALU_ADD;
      OP_ANDI: alu_op_o = ALU_AND;
      OP_ORI:  alu_op_o = ALU_OR;
      OP_XORI: alu_op_o = ALU_XOR;
      OP_SLTI: alu_op_o = ALU_SLT;
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: alu_op_o = ALU_ADD;
      default: is_legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM. Control word is registered from the next state, so every output
// except pc_en changes only on a clock edge or asynchronously to FETCH values on reset.
module mips_mc_control
  import mips_mc_control_pkg::*;
#(
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [3:0] alu_op,
  output logic       pc_en,
  output logic       halted,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d, funct_q, funct_d;
  ctrl_t      ctrl_q;
  logic [3:0] dec_alu_op;
  logic       dec_legal;
  logic       branch_taken;

  // Decode runs on the values that will be latched, so the registered EXEC word is ready in time.
  assign op_d    = (state_q == S_DECODE) ? opcode : op_q;
  assign funct_d = (state_q == S_DECODE) ? funct  : funct_q;

  mips_alu_dec u_alu_dec (
    .opcode_i  (op_d),
    .funct_i   (funct_d),
    .alu_op_o  (dec_alu_op),
    .is_legal_o(dec_legal)
  );

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (!dec_legal) begin
          state_d = TRAP_ILLEGAL ? S_HALT : S_FETCH;
        end else begin
          case (opcode)
            OP_LW, OP_SW:   state_d = S_MEMADR;
            OP_BEQ, OP_BNE: state_d = S_BRANCH;
            OP_J:           state_d = S_JUMP;
            default:        state_d = S_EXEC;
          endcase
        end
      end
      S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      funct_q <= '0;
      ctrl_q  <= ctrl_outs(S_FETCH, 1'b0, ALU_ADD);
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      funct_q <= funct_d;
      ctrl_q  <= ctrl_outs(state_d, op_d == OP_RTYPE, dec_alu_op);
    end
  end

  assign branch_taken = (state_q == S_BRANCH) && ((op_q == OP_BEQ) ? zero : !zero);
  assign pc_en        = ctrl_q.pc_write | branch_taken;

  assign ir_write   = ctrl_q.ir_write;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign iord       = ctrl_q.iord;
  assign reg_write  = ctrl_q.reg_write;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign pc_src     = ctrl_q.pc_src;
  assign alu_op     = ctrl_q.alu_op;
  assign halted     = ctrl_q.halted;
  assign state      = state_q;

endmodule
